vm_controller: RTL and testbench
================================

VM_CONTROLLER -- requirements
Module: vm_controller

Interface
REQ-001 Parameter: CREDIT_W, 8, credit/change width in currency units.
REQ-002 clk  input  1  single system clock, all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 coin_valid  input  1  one-cycle coin-insert strobe.
REQ-005 coin_code  input  2  coin denomination: 00=1, 01=2, 10=5, 11=10 units.
REQ-006 product_sel  input  3  selected product index 0..7.
REQ-007 product_ready  input  1  customer purchase request for product_sel.
REQ-008 cancel  input  1  customer refund request.
REQ-009 credit  output  CREDIT_W  current accumulated credit.
REQ-010 busy  output  1  transaction in progress; new requests ignored.
REQ-011 product_valid  output  1  one-cycle dispense pulse.
REQ-012 product_id  output  3  dispensed product, valid with product_valid.
REQ-013 deny  output  1  one-cycle pulse: request rejected, insufficient credit.
REQ-014 change_valid  output  1  one-cycle change-payout pulse.
REQ-015 change_value  output  CREDIT_W  payout amount, valid with change_valid.
REQ-016 no_change  output  1  high only together with change_valid when change_value==0.
REQ-017 coin_reject  output  1  one-cycle pulse, cycle after a coin that was not accepted.

Function
REQ-018 The FSM SHALL have states IDLE, VEND, CHANGE; busy SHALL be 1 in VEND and CHANGE, 0 in IDLE.
REQ-019 Price table, fixed: products 0..7 = 5, 10, 12, 15, 20, 25, 30, 50 units.
REQ-020 IDLE, coin_valid only: credit SHALL increase by the coin value at the next edge; if the sum exceeds 2^CREDIT_W-1, credit is unchanged and coin_reject pulses next cycle.
REQ-021 IDLE, product_ready at edge T with credit >= price: product_sel latched, go VEND; at T+1 product_valid=1, busy=1, product_id=latched index.
REQ-022 VEND SHALL last exactly one cycle, then CHANGE; at T+2 change_valid=1, change_value=credit-price, no_change=(change_value==0), busy=1.
REQ-023 CHANGE SHALL last exactly one cycle, then IDLE with credit=0 (T+3).
REQ-024 IDLE, product_ready with credit < price: stay IDLE, credit unchanged, deny=1 at T+1, no product_valid, busy stays 0.
REQ-025 IDLE, cancel with credit>0: go directly to CHANGE; change_value=credit, no product_valid; cancel with credit==0 SHALL be ignored.
REQ-026 Simultaneous in IDLE: cancel over product_ready; either request over coin_valid, coin SHALL be rejected (coin_reject next cycle).
REQ-027 In VEND/CHANGE: product_ready and cancel ignored; coin_valid rejected with coin_reject.
REQ-028 All pulse outputs SHALL be registered, high for exactly one cycle; change_value/product_id SHALL read 0 when their strobe is low.
REQ-029 Subtraction SHALL be unsigned, CREDIT_W bits; underflow is impossible by REQ-021.

Reset
REQ-030 While rst=1: state IDLE, credit=0, every output 0, asynchronously.
REQ-031 Reset during VEND/CHANGE SHALL abandon the transaction: credit lost, no further pulses after release.
REQ-032 First transaction SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-033 Package vm_pkg SHALL hold: coin_code enum, state enum, price table constant, coin-value function, CREDIT_W default.
REQ-034 Sub-module vm_credit SHALL implement the saturating-check credit accumulator (add, clear, overflow reject); the FSM stays in vm_controller.

Verification
REQ-035 Coins 10+2 (credit 12), product_ready sel=2 -> T+1 product_valid id=2 busy=1; T+2 change_valid value=0 no_change=1; T+3 credit=0, busy=0.
REQ-036 Coins 10+10+5 (25), product_ready sel=1 -> product_valid id=1; change_value=15, no_change=0.
REQ-037 Credit 5, product_ready sel=7 -> deny pulse T+1, no product_valid, credit stays 5.
REQ-038 Credit 250, coin 10 -> coin_reject next cycle, credit stays 250; coin 5 -> credit 255.
REQ-039 Credit 12, cancel and product_ready same cycle -> change_valid value=12, no product_valid; coin during CHANGE -> coin_reject.
REQ-040 Reset asserted in VEND -> all outputs 0 immediately, credit 0, no change_valid after release; assertions ready->valid/busy (accepted requests) and no_change->change_valid hold throughout.

Source files
------------

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - vending machine shared types, price table and coin decode
package vm_pkg;

  localparam int CREDIT_W_DEF = 8;

  typedef enum logic [1:0] {
    COIN_1  = 2'b00,
    COIN_2  = 2'b01,
    COIN_5  = 2'b10,
    COIN_10 = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_e;

  localparam logic [7:0] PRICE_TABLE [8] = '{8'd5, 8'd10, 8'd12, 8'd15, 8'd20, 8'd25, 8'd30, 8'd50};

  function automatic logic [3:0] coin_value(input coin_e c);
    case (c)
      COIN_1:  return 4'd1;
      COIN_2:  return 4'd2;
      COIN_5:  return 4'd5;
      default: return 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/vm_credit.sv
// rtl/vm_credit.sv - credit accumulator that refuses any coin that would wrap
module vm_credit
  import vm_pkg::*;
#(
  parameter int CREDIT_W = CREDIT_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                add_en_i,
  input  logic [3:0]          add_val_i,
  input  logic                clr_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                ovf_o
);

  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W:0]   sum;

  // One extra bit catches a carry out of the credit range.
  assign sum      = {1'b0, credit_q} + {{(CREDIT_W-3){1'b0}}, add_val_i};
  assign ovf_o    = sum[CREDIT_W];
  assign credit_o = credit_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credit_q <= '0;
    end else if (clr_i) begin
      credit_q <= '0;
    end else if (add_en_i && !ovf_o) begin
      credit_q <= sum[CREDIT_W-1:0];
    end
  end

endmodule

// File: rtl/vm_controller.sv
// rtl/vm_controller.sv - vending FSM: coin intake, purchase/deny, change payout
module vm_controller
  import vm_pkg::*;
#(
  parameter int CREDIT_W = CREDIT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic [2:0]          product_sel,
  input  logic                product_ready,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                product_valid,
  output logic [2:0]          product_id,
  output logic                deny,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_value,
  output logic                no_change,
  output logic                coin_reject
);

  state_e              state_q;
  logic [CREDIT_W-1:0] price_q;
  logic [CREDIT_W-1:0] price_d;
  logic [CREDIT_W-1:0] credit_q;
  logic                busy_q, product_valid_q, deny_q, change_valid_q, no_change_q, coin_reject_q;
  logic [2:0]          product_id_q;
  logic [CREDIT_W-1:0] change_value_q;
  logic                ovf, req, coin_add;

  assign price_d  = CREDIT_W'(PRICE_TABLE[product_sel]);
  // A cancel with nothing to refund is not a request, so it does not block a coin.
  assign req      = product_ready | (cancel & (credit_q != '0));
  assign coin_add = coin_valid & (state_q == ST_IDLE) & ~req;

  vm_credit #(.CREDIT_W(CREDIT_W)) u_credit (
    .clk_i     (clk),
    .rst_i     (rst),
    .add_en_i  (coin_add),
    .add_val_i (coin_value(coin_e'(coin_code))),
    .clr_i     (state_q == ST_CHANGE),
    .credit_o  (credit_q),
    .ovf_o     (ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      price_q         <= '0;
      busy_q          <= 1'b0;
      product_valid_q <= 1'b0;
      product_id_q    <= '0;
      deny_q          <= 1'b0;
      change_valid_q  <= 1'b0;
      change_value_q  <= '0;
      no_change_q     <= 1'b0;
      coin_reject_q   <= 1'b0;
    end else begin
      product_valid_q <= 1'b0;
      product_id_q    <= '0;
      deny_q          <= 1'b0;
      change_valid_q  <= 1'b0;
      change_value_q  <= '0;
      no_change_q     <= 1'b0;
      coin_reject_q   <= coin_valid & ~(coin_add & ~ovf);
      case (state_q)
        ST_IDLE: begin
          if (cancel && credit_q != '0) begin
            state_q        <= ST_CHANGE;
            busy_q         <= 1'b1;
            change_valid_q <= 1'b1;
            change_value_q <= credit_q;
          end else if (product_ready) begin
            if (credit_q >= price_d) begin
              state_q         <= ST_VEND;
              busy_q          <= 1'b1;
              price_q         <= price_d;
              product_valid_q <= 1'b1;
              product_id_q    <= product_sel;
            end else begin
              deny_q <= 1'b1;
            end
          end
        end
        ST_VEND: begin
          state_q        <= ST_CHANGE;
          change_valid_q <= 1'b1;
          change_value_q <= credit_q - price_q;
          no_change_q    <= (credit_q == price_q);
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign credit        = credit_q;
  assign busy          = busy_q;
  assign product_valid = product_valid_q;
  assign product_id    = product_id_q;
  assign deny          = deny_q;
  assign change_valid  = change_valid_q;
  assign change_value  = change_value_q;
  assign no_change     = no_change_q;
  assign coin_reject   = coin_reject_q;

endmodule

// File: tb/tb_vm_controller.sv
// tb/tb_vm_controller.sv - randomized bench for vm_controller against a transaction-level model
module tb_vm_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_code = '0;
  logic [2:0] product_sel = '0;
  logic       product_ready = 1'b0;
  logic       cancel = 1'b0;
  logic [7:0] credit;
  logic       busy, product_valid, deny, change_valid, no_change, coin_reject;
  logic [2:0] product_id;
  logic [7:0] change_value;

  int n_total = 0;
  int n_bad   = 0;

  int price [8] = '{5, 10, 12, 15, 20, 25, 30, 50};
  int coinv [4] = '{1, 2, 5, 10};

  int m_credit = 0;
  int m_left   = 0;
  int m_change = 0;
  int e_pv, e_id, e_deny, e_cv, e_cval, e_nc, e_crej, e_busy, e_credit;

  vm_controller #(.CREDIT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .coin_valid    (coin_valid),
    .coin_code     (coin_code),
    .product_sel   (product_sel),
    .product_ready (product_ready),
    .cancel        (cancel),
    .credit        (credit),
    .busy          (busy),
    .product_valid (product_valid),
    .product_id    (product_id),
    .deny          (deny),
    .change_valid  (change_valid),
    .change_value  (change_value),
    .no_change     (no_change),
    .coin_reject   (coin_reject)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_left   = 0;
    m_change = 0;
  endtask

  // Transaction-level view: a purchase owns the machine for two cycles, a refund for one.
  task automatic model_step(input bit cv, input bit [1:0] code, input bit [2:0] sel,
                            input bit pr, input bit cn);
    bit req;
    e_pv = 0; e_id = 0; e_deny = 0; e_cv = 0; e_cval = 0; e_crej = 0;
    if (m_left == 0) begin
      req = pr || (cn && m_credit > 0);
      if (cn && m_credit > 0) begin
        e_cv = 1; e_cval = m_credit; m_left = 1;
      end else if (pr) begin
        if (m_credit >= price[sel]) begin
          e_pv = 1; e_id = sel; m_change = m_credit - price[sel]; m_left = 2;
        end else begin
          e_deny = 1;
        end
      end
      if (cv) begin
        if (req || m_credit + coinv[code] > 255) e_crej = 1;
        else m_credit += coinv[code];
      end
    end else begin
      if (cv) e_crej = 1;
      m_left--;
      if (m_left == 1) begin
        e_cv = 1; e_cval = m_change;
      end else begin
        m_credit = 0;
      end
    end
    e_nc     = (e_cv && e_cval == 0) ? 1 : 0;
    e_busy   = (m_left > 0) ? 1 : 0;
    e_credit = m_credit;
  endtask

  task automatic compare_all();
    check("credit", credit, e_credit);
    check("busy", busy, e_busy);
    check("product_valid", product_valid, e_pv);
    check("product_id", product_id, e_id);
    check("deny", deny, e_deny);
    check("change_valid", change_valid, e_cv);
    check("change_value", change_value, e_cval);
    check("no_change", no_change, e_nc);
    check("coin_reject", coin_reject, e_crej);
    check("prop_nc_implies_cv", int'(no_change && !change_valid), 0);
    check("prop_pv_implies_busy", int'(product_valid && !busy), 0);
  endtask

  task automatic cycle(input bit cv, input bit [1:0] code, input bit [2:0] sel,
                       input bit pr, input bit cn);
    @(negedge clk);
    rst           = 1'b0;
    coin_valid    = cv;
    coin_code     = code;
    product_sel   = sel;
    product_ready = pr;
    cancel        = cn;
    model_step(cv, code, sel, pr, cn);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic coin(input bit [1:0] code);
    cycle(1'b1, code, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_credit"}, credit, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pulses"}, int'({product_valid, deny, change_valid, no_change, coin_reject}), 0);
    check({tag, "_values"}, int'({product_id, change_value}), 0);
  endtask

  initial begin
    bit cv, pr, cn;
    bit [1:0] code;
    bit [2:0] sel;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    model_reset();

    // 12 credit, buy product 2 exactly
    coin(2'd3);
    coin(2'd1);
    check("d35_credit", credit, 12);
    cycle(1'b0, 2'd0, 3'd2, 1'b1, 1'b0);
    check("d35_pv", product_valid, 1);
    check("d35_id", product_id, 2);
    idle();
    check("d35_cval", change_value, 0);
    check("d35_nc", no_change, 1);
    idle();
    check("d35_end_credit", credit, 0);
    check("d35_end_busy", busy, 0);

    // 25 credit, buy product 1, 15 back
    coin(2'd3); coin(2'd3); coin(2'd2);
    cycle(1'b0, 2'd0, 3'd1, 1'b1, 1'b0);
    check("d36_id", product_id, 1);
    idle();
    check("d36_cval", change_value, 15);
    check("d36_nc", no_change, 0);
    idle();

    // insufficient credit
    coin(2'd2);
    cycle(1'b0, 2'd0, 3'd7, 1'b1, 1'b0);
    check("d37_deny", deny, 1);
    check("d37_pv", product_valid, 0);
    check("d37_credit", credit, 5);
    cycle(1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
    idle();

    // overflow boundary at 255
    repeat (25) coin(2'd3);
    check("d38_250", credit, 250);
    coin(2'd3);
    check("d38_reject", coin_reject, 1);
    check("d38_hold", credit, 250);
    coin(2'd2);
    check("d38_255", credit, 255);
    cycle(1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
    idle();

    // cancel beats purchase; coin during CHANGE is rejected
    coin(2'd3); coin(2'd1);
    cycle(1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    check("d39_cval", change_value, 12);
    check("d39_pv", product_valid, 0);
    coin(2'd0);
    check("d39_crej", coin_reject, 1);
    idle();

    // reset in VEND abandons the sale
    coin(2'd3); coin(2'd3);
    cycle(1'b0, 2'd0, 3'd1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_all_zero("d40_async");
    model_reset();
    repeat (3) idle();
    check("d40_credit", credit, 0);

    for (int i = 0; i < 3000; i++) begin
      cv   = ($urandom_range(0, 99) < 55);
      code = 2'($urandom_range(0, 3));
      sel  = 3'($urandom_range(0, 7));
      pr   = ($urandom_range(0, 99) < 8);
      cn   = ($urandom_range(0, 99) < 3);
      cycle(cv, code, sel, pr, cn);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
